core2wb_pipelined: RTL and testbench

CORE2WB_PIPELINED -- requirements
Module: core2wb_pipelined

---
 rtl/core2wb_pipelined_if.sv | 43 ++++
 rtl/core2wb_pipelined.sv | 111 +++++++++++
 tb/tb_core2wb_pipelined.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/core2wb_pipelined_if.sv
// rtl/core2wb_pipelined_if.sv - core request/response and Wishbone B4 pipelined bus bundle
// master: the bridge view; slave: the core + Wishbone slave environment view.
interface core2wb_pipelined_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          core_req_i;
  logic          core_gnt_o;
  logic          core_we_i;
  logic [SW-1:0] core_be_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_wdata_i;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          core_err_o;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_m_o;
  logic          wb_stall_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic [DW-1:0] wb_dat_s_i;

  modport master (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_m_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_s_i
  );

  modport slave (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_m_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_s_i
  );
endinterface

// File: rtl/core2wb_pipelined.sv
// rtl/core2wb_pipelined.sv - core-to-Wishbone B4 pipelined bridge with outstanding limit and timeout abort
// Responses are registered once and returned in issue order; a stuck slave is flushed through ABORT.
module core2wb_pipelined #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  core2wb_pipelined_if.master  bus,
  output logic                 timeout_o
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] TSAT  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic          stb, gnt, rsp;

  always_comb begin
    stb = bus.core_req_i && (cnt_q < MAX_C) && (state_q != ABORT);
    gnt = stb && !bus.wb_stall_i;
    rsp = (bus.wb_ack_i || bus.wb_err_i) && (cnt_q != '0) && (state_q != ABORT);

    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    timeout_d = 1'b0;

    if (state_q == ABORT) begin
      // Flush one outstanding transaction per cycle as an error, ignoring the bus.
      tmr_d = '0;
      if (cnt_q != '0) begin
        cnt_d    = cnt_q - 1'b1;
        rvalid_d = 1'b1;
        err_d    = 1'b1;
      end
      state_d = (cnt_d == '0) ? IDLE : ABORT;
    end else begin
      if (gnt && !rsp) begin
        cnt_d = cnt_q + 1'b1;
      end else if (rsp && !gnt) begin
        cnt_d = cnt_q - 1'b1;
      end

      rvalid_d = rsp;
      err_d    = rsp && bus.wb_err_i;
      rdata_d  = rsp ? bus.wb_dat_s_i : '0;

      if (gnt || rsp || (cnt_q == '0)) begin
        tmr_d = '0;
      end else if (tmr_q != TSAT) begin
        tmr_d = tmr_q + 1'b1;
      end

      // tmr_d can only reach the limit in a cycle with no grant and no response.
      if ((TIMEOUT != 0) && (tmr_d == TMO_C)) begin
        state_d   = ABORT;
        timeout_d = 1'b1;
      end else begin
        state_d = (cnt_d == '0) ? IDLE : BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.wb_stb_o      = stb;
  assign bus.core_gnt_o    = gnt;
  assign bus.wb_cyc_o      = (stb || (cnt_q != '0)) && (state_q != ABORT);
  assign bus.wb_we_o       = bus.core_we_i;
  assign bus.wb_adr_o      = bus.core_addr_i;
  assign bus.wb_sel_o      = bus.core_be_i;
  assign bus.wb_dat_m_o    = bus.core_wdata_i;
  assign bus.core_rvalid_o = rvalid_q;
  assign bus.core_err_o    = err_q;
  assign bus.core_rdata_o  = rdata_q;
  assign timeout_o         = timeout_q;
endmodule

// File: tb/tb_core2wb_pipelined.sv
// tb/tb_core2wb_pipelined.sv - directed and randomized self-checking bench for core2wb_pipelined
module tb_core2wb_pipelined;
  localparam int MAXO = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout;
  always #5 clk = ~clk;

  core2wb_pipelined_if #(.AW(32), .DW(32)) bus ();

  core2wb_pipelined #(.AW(32), .DW(32), .MAX_OUT(MAXO), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .timeout_o (timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] pend[$];
  bit          m_abort;
  int          m_idle;
  bit          exp_rv, exp_err, exp_to;
  logic [31:0] exp_rd;
  int          gcount, rvcount, tocount;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_abort = 1'b0;
    m_idle  = 0;
    exp_rv  = 1'b0;
    exp_err = 1'b0;
    exp_to  = 1'b0;
    exp_rd  = '0;
  endtask

  // One bus cycle: drive after the falling edge, check combinational outputs,
  // advance the model on the rising edge, check registered outputs on the next falling edge.
  task automatic step(input bit req, input logic [31:0] addr, input bit stall,
                      input bit ack, input bit err, input logic [31:0] dat);
    bit          we;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          m_stb, m_gnt, m_cyc, m_rsp;
    int          n;
    we = 1'($urandom_range(0, 1));
    be = 4'($urandom);
    wd = $urandom;
    bus.core_req_i   = req;
    bus.core_we_i    = we;
    bus.core_be_i    = be;
    bus.core_addr_i  = addr;
    bus.core_wdata_i = wd;
    bus.wb_stall_i   = stall;
    bus.wb_ack_i     = ack;
    bus.wb_err_i     = err;
    bus.wb_dat_s_i   = dat;
    #1;
    n     = pend.size();
    m_stb = req && (n < MAXO) && !m_abort;
    m_gnt = m_stb && !stall;
    m_cyc = (m_stb || n > 0) && !m_abort;
    m_rsp = !m_abort && (n > 0) && (ack || err);
    check("wb_stb", bus.wb_stb_o, m_stb);
    check("core_gnt", bus.core_gnt_o, m_gnt);
    check("wb_cyc", bus.wb_cyc_o, m_cyc);
    check("wb_adr", bus.wb_adr_o, addr);
    check("wb_we", bus.wb_we_o, we);
    check("wb_sel", bus.wb_sel_o, be);
    check("wb_dat_m", bus.wb_dat_m_o, wd);
    if (bus.core_gnt_o === 1'b1) gcount++;
    @(posedge clk);
    if (m_abort) begin
      exp_to = 1'b0;
      m_idle = 0;
      void'(pend.pop_front());
      exp_rv  = 1'b1;
      exp_err = 1'b1;
      exp_rd  = '0;
      if (pend.size() == 0) m_abort = 1'b0;
    end else begin
      exp_rv  = m_rsp;
      exp_err = m_rsp && err;
      exp_rd  = dat;
      exp_to  = 1'b0;
      if (m_rsp) void'(pend.pop_front());
      if (m_gnt) pend.push_back(addr);
      if (m_gnt || m_rsp || n == 0) m_idle = 0;
      else m_idle++;
      if (m_idle == TMO) begin
        m_abort = 1'b1;
        exp_to  = 1'b1;
        m_idle  = 0;
      end
    end
    @(negedge clk);
    check("core_rvalid", bus.core_rvalid_o, exp_rv);
    check("timeout_o", timeout, exp_to);
    if (exp_rv) begin
      check("core_err", bus.core_err_o, exp_err);
      check("core_rdata", bus.core_rdata_o, exp_rd);
    end
    if (bus.core_rvalid_o === 1'b1) rvcount++;
    if (timeout === 1'b1) tocount++;
  endtask

  initial begin
    bus.core_req_i   = 1'b0;
    bus.core_we_i    = 1'b0;
    bus.core_be_i    = '0;
    bus.core_addr_i  = '0;
    bus.core_wdata_i = '0;
    bus.wb_stall_i   = 1'b0;
    bus.wb_ack_i     = 1'b0;
    bus.wb_err_i     = 1'b0;
    bus.wb_dat_s_i   = '0;
    model_reset();
    #1;
    check("rst_rvalid", bus.core_rvalid_o, 1'b0);
    check("rst_rdata", bus.core_rdata_o, 32'h0);
    check("rst_err", bus.core_err_o, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_cyc", bus.wb_cyc_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single read
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    check("single_rdata", bus.core_rdata_o, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // fill to MAX_OUT with no acks, then drain in order
    gcount = 0;
    rvcount = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 32'h0);
    check("fill_grants", gcount, 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, tag_of(pend[0]));
      check("inorder_rdata", bus.core_rdata_o, tag_of(32'h200 + 32'(4 * i)));
    end
    check("drain_rvalids", rvcount, 4);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // simultaneous grant and ack, then stall
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h308, 1'b0, 1'b1, 1'b0, tag_of(pend[0]));
    check("simul_outstanding", pend.size(), 2);
    repeat (3) step(1'b1, 32'h30C, 1'b1, 1'b0, 1'b0, 32'h0);
    while (pend.size() > 0) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, tag_of(pend[0]));
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // error response and spurious ack
    step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    check("ackerr_err", bus.core_err_o, 1'b1);
    rvcount = 0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h66);
    check("spurious_rvalid", rvcount, 0);

    // timeout and abort flush
    tocount = 0;
    rvcount = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (TMO) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("timeout_pulse", timeout, 1'b1);
    repeat (3) step(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("abort_rvalids", rvcount, 3);
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post_abort_grant", gcount > 0 && pend.size() == 1, 1'b1);
    check("timeout_count", tocount, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, tag_of(pend[0]));

    // asynchronous reset with three outstanding and a response on the output
    for (int i = 0; i < 4; i++) step(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, tag_of(pend[0]));
    check("pre_rst_rvalid", bus.core_rvalid_o, 1'b1);
    bus.wb_ack_i   = 1'b0;
    bus.core_req_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rvalid", bus.core_rvalid_o, 1'b0);
    check("async_rdata", bus.core_rdata_o, 32'h0);
    check("async_err", bus.core_err_o, 1'b0);
    check("async_stb", bus.wb_stb_o, 1'b1);
    check("async_cyc", bus.wb_cyc_o, 1'b1);
    bus.core_req_i = 1'b0;
    #1;
    check("async_cyc_noreq", bus.wb_cyc_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    rvcount = 0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h77);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_stale", rvcount, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      bit ack, err;
      a   = {$urandom_range(0, 255), 2'b00};
      ack = ($urandom_range(0, 2) == 0);
      err = ($urandom_range(0, 7) == 0);
      d   = (pend.size() > 0) ? tag_of(pend[0]) : $urandom;
      step(1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) == 0), ack, err, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
